kernel_channel_mac_array: RTL and testbench
===========================================

KERNEL_CHANNEL_MAC_ARRAY -- requirements
Module: kernel_channel_mac_array

Interface
REQ-001 SHALL provide parameter BIT_WIDTH, default 8: signed data/weight width.
REQ-002 SHALL provide parameter PSUM_WIDTH, default 16: signed psum/accumulator width, legal iff >= 2*BIT_WIDTH.
REQ-003 SHALL provide parameter NUM_CHANNEL, default 3: channels per beat and pipeline depth, legal iff >= 1.
REQ-004 SHALL provide parameter NUM_KERNEL, default 4: parallel kernels, legal iff 1..REG_WIDTH-1.
REQ-005 SHALL provide parameter REG_WIDTH, default 32: error register width.
REQ-006 SHALL use one clock and an asynchronous, active-high reset; clock and reset ports are clk and rst.
REQ-007 SHALL provide ports:
  clk  in  1  clock
  rst  in  1  asynchronous active-high reset
  i_data  in  BIT_WIDTH*NUM_CHANNEL  channel c at slice c
  i_data_val  in  1  beat valid
  i_weight  in  BIT_WIDTH*NUM_KERNEL*NUM_CHANNEL  weight (k,c) at slice k*NUM_CHANNEL+c
  i_weight_val  in  1  weight-load request
  i_psum  in  PSUM_WIDTH*NUM_KERNEL  per-kernel psum input, kernel k at slice k
  i_acc_en  in  1  accumulate this beat across beats
  i_last  in  1  final beat of an accumulation group
  i_err_clr  in  1  clear sticky error bits
  o_psum  out  PSUM_WIDTH*NUM_KERNEL  per-kernel result
  o_psum_val  out  NUM_KERNEL  result valid, all bits equal
  o_busy  out  1  beat in flight or accumulation group open
  err_psum_val  out  REG_WIDTH  sticky error register

Function
REQ-008 SHALL hold weights in a NUM_KERNEL x NUM_CHANNEL register file, loaded from i_weight on an accepted load.
REQ-009 SHALL accept a load iff i_weight_val=1, i_data_val=0 and o_busy=0; a load offered under any other condition SHALL be ignored and SHALL set err_psum_val[NUM_KERNEL].
REQ-010 SHALL delay channel c data internally by c cycles so that all channels of one beat are presented at the same cycle.
REQ-011 SHALL compute per kernel the chain s0=sext(i_psum_k)+d0*w(k,0), sc=s(c-1)+dc*w(k,c); one registered stage per channel; products are full 2*BIT_WIDTH signed.
REQ-012 SHALL saturate every adder to the signed PSUM_WIDTH range; any saturation on kernel k SHALL set err_psum_val[k].
REQ-013 SHALL carry i_data_val, i_acc_en and i_last down the pipeline with their beat.
REQ-014 SHALL drive the final stage as follows:
  - beat with acc_en=0: output chain result directly.
  - beat with acc_en=1: add chain result, saturating, to the accumulator; the first beat of a group loads the accumulator instead of adding.
  - beat with acc_en=1 and last=1: output the accumulator sum and close the group.
REQ-015 SHALL assert o_psum_val for exactly one cycle per emitted result; latency is NUM_CHANNEL+1 cycles from the i_data_val beat to o_psum_val; throughput is one beat per cycle.
REQ-016 SHALL hold o_psum at its last emitted value while o_psum_val=0.
REQ-017 SHALL drive o_busy=1 while any pipeline stage holds a valid beat or an accumulation group is open.
REQ-018 SHALL treat an acc_en=0 beat arriving inside an open group as closing the group: emit the beat's own result only and discard the accumulator, and set err_psum_val[NUM_KERNEL+1] if NUM_KERNEL+1 < REG_WIDTH.
REQ-019 SHALL clear all err_psum_val bits on i_err_clr=1; a set event in the same cycle as i_err_clr SHALL win. Unused bits SHALL read 0.

Reset
REQ-020 rst=1 SHALL immediately clear the following to 0: weights, pipeline, valids, accumulator, group state, o_psum, o_psum_val, o_busy and err_psum_val.
REQ-021 Beats in flight at reset SHALL be discarded; no o_psum_val SHALL assert until a new beat completes the full latency after reset release.

Verification (defaults BIT_WIDTH=8, PSUM_WIDTH=16, NUM_CHANNEL=3, NUM_KERNEL=4)
REQ-022 Load w(0,*)=(2,3,4), then one beat d=(1,2,3), psum0=10, acc_en=0 -> kernel0 o_psum=30, o_psum_val one pulse 4 cycles after the beat.
REQ-023 Four back-to-back beats with psum0=0,1,2,3 (same data) -> results 20,21,22,23 on consecutive cycles, in order.
REQ-024 Three beats from REQ-022 with acc_en=1, i_last on the third -> single o_psum_val with kernel0=90, 4 cycles after the third beat; o_busy falls the cycle after the output.
REQ-025 d=(127,127,127), w=127, psum=32767 -> o_psum=32767, err_psum_val[k]=1; i_err_clr -> 0.
REQ-026 i_weight_val while o_busy=1 -> weights unchanged, err_psum_val[4]=1, next result uses old weights.
REQ-027 Assert rst two cycles after a beat -> outputs 0 at once, no o_psum_val after release.

Source files
------------

// File: rtl/kernel_channel_mac_array.sv
// Weight-stationary MAC array: NUM_KERNEL kernels, each a NUM_CHANNEL-deep systolic
// chain of saturating multiply-adds, followed by an optional cross-beat accumulator.
module kernel_channel_mac_array #(
    parameter int BIT_WIDTH   = 8,
    parameter int PSUM_WIDTH  = 16,
    parameter int NUM_CHANNEL = 3,
    parameter int NUM_KERNEL  = 4,
    parameter int REG_WIDTH   = 32
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [BIT_WIDTH*NUM_CHANNEL-1:0]           i_data,
    input  logic                                       i_data_val,
    input  logic [BIT_WIDTH*NUM_KERNEL*NUM_CHANNEL-1:0] i_weight,
    input  logic                                       i_weight_val,
    input  logic [PSUM_WIDTH*NUM_KERNEL-1:0]           i_psum,
    input  logic                                       i_acc_en,
    input  logic                                       i_last,
    input  logic                                       i_err_clr,
    output logic [PSUM_WIDTH*NUM_KERNEL-1:0]           o_psum,
    output logic [NUM_KERNEL-1:0]                      o_psum_val,
    output logic                                       o_busy,
    output logic [REG_WIDTH-1:0]                       err_psum_val
);
    localparam int BW = BIT_WIDTH;
    localparam int PW = PSUM_WIDTH;
    localparam int NC = NUM_CHANNEL;
    localparam int NK = NUM_KERNEL;
    localparam bit HAS_GRP_ERR = (NK + 1 < REG_WIDTH);
    localparam int ERR_GRP = HAS_GRP_ERR ? NK + 1 : NK;
    localparam logic [PW-1:0] PSUM_MAX = {1'b0, {(PW-1){1'b1}}};
    localparam logic [PW-1:0] PSUM_MIN = {1'b1, {(PW-1){1'b0}}};

    // Returns {saturated, clamped_sum}.
    function automatic logic [PW:0] sat_add(input logic [PW-1:0] a, input logic [PW-1:0] b);
        logic [PW:0] s;
        s = {a[PW-1], a} + {b[PW-1], b};
        if (s[PW] != s[PW-1]) return {1'b1, (s[PW] ? PSUM_MIN : PSUM_MAX)};
        return {1'b0, s[PW-1:0]};
    endfunction

    logic signed [BW-1:0] w_q     [NK][NC];
    logic        [BW-1:0] d_al    [NC];
    logic signed [PW-1:0] sum_q   [NC][NK];
    logic signed [PW-1:0] sum_d   [NC][NK];
    logic signed [PW-1:0] in_sum  [NC][NK];
    logic [NC-1:0]        val_q, acc_q, last_q;
    logic [NC-1:0]        in_val, in_acc, in_last;
    logic signed [PW-1:0] accum_q [NK];
    logic signed [PW-1:0] accum_d [NK];
    logic                 group_open_q;
    logic [PW*NK-1:0]     o_psum_q;
    logic                 o_psum_val_q;
    logic [REG_WIDTH-1:0] err_q, err_d, err_set;
    logic [NK-1:0]        sat_k, acc_sat;
    logic                 load_ok, fv, fa, fl;

    // Channel c is skewed by c cycles so it meets its beat at chain stage c.
    for (genvar c = 0; c < NC; c++) begin : g_skew
        if (c == 0) begin : g_direct
            assign d_al[0] = i_data[BW-1:0];
        end else begin : g_delay
            logic [BW-1:0] sr_q [c];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int j = 0; j < c; j++) sr_q[j] <= '0;
                end else begin
                    sr_q[0] <= i_data[c*BW +: BW];
                    for (int j = 1; j < c; j++) sr_q[j] <= sr_q[j-1];
                end
            end
            assign d_al[c] = sr_q[c-1];
        end
    end

    assign load_ok = i_weight_val && !i_data_val && !o_busy;
    assign fv = val_q[NC-1];
    assign fa = acc_q[NC-1];
    assign fl = last_q[NC-1];

    always_comb begin
        logic signed [2*BW-1:0] prod;
        logic [PW:0]            r;
        sat_k   = '0;
        in_val  = '0;
        in_acc  = '0;
        in_last = '0;
        in_val[0]  = i_data_val;
        in_acc[0]  = i_acc_en;
        in_last[0] = i_last;
        for (int k = 0; k < NK; k++) in_sum[0][k] = i_psum[k*PW +: PW];
        for (int c = 1; c < NC; c++) begin
            in_val[c]  = val_q[c-1];
            in_acc[c]  = acc_q[c-1];
            in_last[c] = last_q[c-1];
            for (int k = 0; k < NK; k++) in_sum[c][k] = sum_q[c-1][k];
        end
        for (int c = 0; c < NC; c++) begin
            for (int k = 0; k < NK; k++) begin
                prod        = signed'(d_al[c]) * w_q[k][c];
                r           = sat_add(in_sum[c][k], PW'(prod));
                sum_d[c][k] = r[PW-1:0];
                if (r[PW] && in_val[c]) sat_k[k] = 1'b1;
            end
        end
    end

    // First beat of a group loads the accumulator; later beats add to it.
    always_comb begin
        logic [PW:0] r;
        acc_sat = '0;
        for (int k = 0; k < NK; k++) begin
            r = sat_add(accum_q[k], sum_q[NC-1][k]);
            accum_d[k] = group_open_q ? r[PW-1:0] : sum_q[NC-1][k];
            acc_sat[k] = group_open_q && r[PW] && fv && fa;
        end
    end

    always_comb begin
        err_set = '0;
        err_set[NK-1:0] = sat_k | acc_sat;
        err_set[NK] = i_weight_val && !load_ok;
        if (HAS_GRP_ERR) err_set[ERR_GRP] = err_set[ERR_GRP] | (fv && !fa && group_open_q);
        err_d = (i_err_clr ? '0 : err_q) | err_set;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NK; k++) begin
                for (int c = 0; c < NC; c++) w_q[k][c] <= '0;
                accum_q[k] <= '0;
            end
            for (int c = 0; c < NC; c++)
                for (int k = 0; k < NK; k++) sum_q[c][k] <= '0;
            val_q        <= '0;
            acc_q        <= '0;
            last_q       <= '0;
            group_open_q <= 1'b0;
            o_psum_q     <= '0;
            o_psum_val_q <= 1'b0;
            err_q        <= '0;
        end else begin
            if (load_ok)
                for (int k = 0; k < NK; k++)
                    for (int c = 0; c < NC; c++) w_q[k][c] <= i_weight[(k*NC+c)*BW +: BW];
            val_q  <= in_val;
            acc_q  <= in_acc;
            last_q <= in_last;
            for (int c = 0; c < NC; c++)
                if (in_val[c])
                    for (int k = 0; k < NK; k++) sum_q[c][k] <= sum_d[c][k];
            o_psum_val_q <= 1'b0;
            if (fv) begin
                if (!fa) begin
                    for (int k = 0; k < NK; k++) o_psum_q[k*PW +: PW] <= sum_q[NC-1][k];
                    o_psum_val_q <= 1'b1;
                    group_open_q <= 1'b0;
                end else if (fl) begin
                    for (int k = 0; k < NK; k++) o_psum_q[k*PW +: PW] <= accum_d[k];
                    o_psum_val_q <= 1'b1;
                    group_open_q <= 1'b0;
                end else begin
                    for (int k = 0; k < NK; k++) accum_q[k] <= accum_d[k];
                    group_open_q <= 1'b1;
                end
            end
            err_q <= err_d;
        end
    end

    assign o_psum       = o_psum_q;
    assign o_psum_val   = {NK{o_psum_val_q}};
    assign o_busy       = (|val_q) | group_open_q | o_psum_val_q;
    assign err_psum_val = err_q;
endmodule

// File: tb/tb_kernel_channel_mac_array.sv
// Directed bench for kernel_channel_mac_array at default parameters.
module tb_kernel_channel_mac_array;
    localparam int BW = 8;
    localparam int PW = 16;
    localparam int NC = 3;
    localparam int NK = 4;
    localparam int RW = 32;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [BW*NC-1:0]      i_data;
    logic                  i_data_val;
    logic [BW*NK*NC-1:0]   i_weight;
    logic                  i_weight_val;
    logic [PW*NK-1:0]      i_psum;
    logic                  i_acc_en;
    logic                  i_last;
    logic                  i_err_clr;
    logic [PW*NK-1:0]      o_psum;
    logic [NK-1:0]         o_psum_val;
    logic                  o_busy;
    logic [RW-1:0]         err_psum_val;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int wtab [NK][NC];
    int pulses;

    kernel_channel_mac_array #(
        .BIT_WIDTH(BW), .PSUM_WIDTH(PW), .NUM_CHANNEL(NC), .NUM_KERNEL(NK), .REG_WIDTH(RW)
    ) dut (
        .clk(clk), .rst(rst),
        .i_data(i_data), .i_data_val(i_data_val),
        .i_weight(i_weight), .i_weight_val(i_weight_val),
        .i_psum(i_psum), .i_acc_en(i_acc_en), .i_last(i_last), .i_err_clr(i_err_clr),
        .o_psum(o_psum), .o_psum_val(o_psum_val), .o_busy(o_busy),
        .err_psum_val(err_psum_val)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int got, input int exp);
        total_cnt++;
        if (got == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int pk(input int k);
        return int'(signed'(o_psum[k*PW +: PW]));
    endfunction

    task automatic idle();
        i_data_val   = 1'b0;
        i_acc_en     = 1'b0;
        i_last       = 1'b0;
        i_weight_val = 1'b0;
        i_err_clr    = 1'b0;
    endtask

    task automatic beat(input int d0, d1, d2, p0, p1, p2, p3, input logic acc, last);
        i_data     = {8'(d2), 8'(d1), 8'(d0)};
        i_psum     = {16'(p3), 16'(p2), 16'(p1), 16'(p0)};
        i_data_val = 1'b1;
        i_acc_en   = acc;
        i_last     = last;
    endtask

    task automatic load_wtab();
        for (int k = 0; k < NK; k++)
            for (int c = 0; c < NC; c++) i_weight[(k*NC+c)*BW +: BW] = 8'(wtab[k][c]);
        i_weight_val = 1'b1;
        tick();
        i_weight_val = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 12 && o_busy; i++) tick();
        check("drain_busy", int'(o_busy), 0);
    endtask

    task automatic clear_err();
        i_err_clr = 1'b1;
        tick();
        i_err_clr = 1'b0;
        check("err_clear", int'(err_psum_val), 0);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        i_data = '0;
        i_psum = '0;
        i_weight = '0;
        tick();
        tick();
        check("rst_psum0", pk(0), 0);
        check("rst_val", int'(o_psum_val), 0);
        check("rst_busy", int'(o_busy), 0);
        check("rst_err", int'(err_psum_val), 0);
        rst = 1'b0;
        tick();

        // Single beat, acc_en=0
        wtab = '{'{2, 3, 4}, '{1, 1, 1}, '{-1, -2, -3}, '{0, 0, 5}};
        load_wtab();
        check("load_err", int'(err_psum_val), 0);
        beat(1, 2, 3, 10, 0, 100, -7, 1'b0, 1'b0);
        tick();
        idle();
        tick();
        tick();
        check("single_early_val", int'(o_psum_val), 0);
        tick();
        check("single_val", int'(o_psum_val), 15);
        check("single_k0", pk(0), 30);
        check("single_k1", pk(1), 6);
        check("single_k2", pk(2), 86);
        check("single_k3", pk(3), 8);
        tick();
        check("single_val_drop", int'(o_psum_val), 0);
        check("single_hold_k0", pk(0), 30);
        drain();

        // Back-to-back beats
        for (int t = 1; t <= 8; t++) begin
            if (t <= 4) beat(1, 2, 3, t - 1, 0, 0, 0, 1'b0, 1'b0);
            else idle();
            tick();
            if (t >= 4 && t <= 7) begin
                check("b2b_val", int'(o_psum_val), 15);
                check("b2b_k0", pk(0), 20 + t - 4);
            end else if (t == 8) begin
                check("b2b_val_end", int'(o_psum_val), 0);
            end
        end
        drain();

        // Three-beat accumulation group
        for (int t = 1; t <= 7; t++) begin
            if (t <= 3) beat(1, 2, 3, 10, 0, 0, 0, 1'b1, t == 3);
            else idle();
            tick();
            if (t < 6) begin
                check("acc_quiet", int'(o_psum_val), 0);
            end else if (t == 6) begin
                check("acc_val", int'(o_psum_val), 15);
                check("acc_k0", pk(0), 90);
                check("acc_k1", pk(1), 18);
                check("acc_busy_out", int'(o_busy), 1);
            end else begin
                check("acc_busy_after", int'(o_busy), 0);
                check("acc_val_after", int'(o_psum_val), 0);
            end
        end

        // Group closed by an acc_en=0 beat
        for (int t = 1; t <= 5; t++) begin
            if (t == 1) beat(1, 2, 3, 10, 0, 0, 0, 1'b1, 1'b0);
            else if (t == 2) beat(1, 2, 3, 10, 0, 0, 0, 1'b0, 1'b0);
            else idle();
            tick();
            if (t == 4) begin
                check("grp_absorb", int'(o_psum_val), 0);
            end else if (t == 5) begin
                check("grp_val", int'(o_psum_val), 15);
                check("grp_k0", pk(0), 30);
                check("grp_err", int'(err_psum_val), 32);
            end
        end
        idle();
        clear_err();
        drain();

        // Weight load while busy is rejected
        beat(1, 2, 3, 10, 0, 0, 0, 1'b0, 1'b0);
        tick();
        idle();
        i_weight = '0;
        i_weight_val = 1'b1;
        tick();
        i_weight_val = 1'b0;
        check("busy_load_err", int'(err_psum_val), 16);
        tick();
        tick();
        check("busy_load_val", int'(o_psum_val), 15);
        check("busy_load_k0", pk(0), 30);
        drain();
        beat(1, 2, 3, 0, 0, 0, 0, 1'b0, 1'b0);
        tick();
        idle();
        tick();
        tick();
        tick();
        check("old_w_val", int'(o_psum_val), 15);
        check("old_w_k0", pk(0), 20);
        drain();
        clear_err();

        // Set event in the same cycle as clear wins
        beat(1, 2, 3, 0, 0, 0, 0, 1'b0, 1'b0);
        i_weight_val = 1'b1;
        i_err_clr = 1'b1;
        tick();
        idle();
        check("clr_vs_set", int'(err_psum_val), 16);
        drain();
        clear_err();

        // Positive and negative saturation
        for (int k = 0; k < NK; k++)
            for (int c = 0; c < NC; c++) wtab[k][c] = 127;
        load_wtab();
        beat(127, 127, 127, 32767, 32767, 32767, 32767, 1'b0, 1'b0);
        tick();
        idle();
        tick();
        tick();
        tick();
        check("satp_val", int'(o_psum_val), 15);
        check("satp_k0", pk(0), 32767);
        check("satp_k3", pk(3), 32767);
        check("satp_err", int'(err_psum_val), 15);
        clear_err();
        beat(-128, -128, -128, -32768, -32768, -32768, -32768, 1'b0, 1'b0);
        tick();
        idle();
        tick();
        tick();
        tick();
        check("satn_k0", pk(0), -32768);
        check("satn_k2", pk(2), -32768);
        check("satn_err", int'(err_psum_val), 15);
        clear_err();
        drain();

        // Reset with a beat in flight
        beat(1, 1, 1, 0, 0, 0, 0, 1'b0, 1'b0);
        tick();
        idle();
        tick();
        check("pre_rst_busy", int'(o_busy), 1);
        rst = 1'b1;
        #1;
        check("rst_now_busy", int'(o_busy), 0);
        check("rst_now_k0", pk(0), 0);
        check("rst_now_val", int'(o_psum_val), 0);
        tick();
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            pulses += int'(o_psum_val[0]);
        end
        check("post_rst_pulses", pulses, 0);
        check("post_rst_k0", pk(0), 0);
        beat(1, 2, 3, 10, 0, 0, 0, 1'b0, 1'b0);
        tick();
        idle();
        tick();
        tick();
        tick();
        check("post_rst_val", int'(o_psum_val), 15);
        check("post_rst_w_cleared_k0", pk(0), 10);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
